// File: rtl/move_list_merger.sv
// rtl/move_list_merger.sv - merges eight column move FIFOs into one serial move stream
//
// Purpose: visits columns 0..7 in order, pops 152-bit words (eight 19-bit moves,
// slot 0 in the most significant bits), drops filler entries, emits real moves
// one per valid/ready handshake and stops a column at its end marker.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start             one-cycle pulse that begins a merge pass (ignored while busy)
//   col_done[i]       column i has finished generating
//   col_empty[i]      column i FIFO has no word available
//   col_data          column i word at [152*i +: 152], valid the cycle after col_rden[i]
//   col_rden          one-hot single-cycle FIFO pop
//   move_out          current move {flags[6:0], from[5:0], to[5:0]}
//   move_valid        move_out valid
//   move_ready        downstream accept
//   move_count        accepted moves this pass, saturating at 255
//   count_ovf         sticky: an accept happened while move_count was 255
//   busy, done        pass in progress / pass complete
module move_list_merger #(
  parameter int NCOL  = 8,
  parameter int MOVW  = 19,
  parameter int WORDW = 152
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NCOL-1:0]       col_done,
  input  logic [NCOL-1:0]       col_empty,
  input  logic [NCOL*WORDW-1:0] col_data,
  output logic [NCOL-1:0]       col_rden,
  output logic [MOVW-1:0]       move_out,
  output logic                  move_valid,
  input  logic                  move_ready,
  output logic [7:0]            move_count,
  output logic                  count_ovf,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {IDLE, WAITC, POP, LOAD, EMIT, DONE} state_t;

  state_t             state;
  logic [2:0]         col_ptr;
  logic [2:0]         slot;
  logic [WORDW-1:0]   word_q;

  logic [WORDW-1:0]   col_word;
  logic [NCOL-1:0]    ptr_onehot;
  logic [MOVW-1:0]    cur_mv;
  logic [MOVW-1:0]    nxt_mv;
  logic [MOVW-1:0]    pres_mv;
  logic               cur_inv;
  logic               cur_end;
  logic               last_col;
  logic               last_slot;

  function automatic logic [MOVW-1:0] slot_of(input logic [WORDW-1:0] w, input int s);
    return w[WORDW-1-MOVW*s -: MOVW];
  endfunction

  assign col_word   = col_data[WORDW*int'(col_ptr) +: WORDW];
  assign ptr_onehot = NCOL'(1) << col_ptr;
  assign cur_mv     = slot_of(word_q, int'(slot));
  assign nxt_mv     = slot_of(word_q, int'(slot + 3'd1));
  assign cur_inv    = cur_mv[MOVW-1];
  assign cur_end    = cur_inv && (cur_mv[11:6] == cur_mv[5:0]);
  assign last_col   = (col_ptr == 3'(NCOL-1));
  assign last_slot  = (slot == 3'd7);

  // The move presented on the next cycle: slot 0 of the incoming word while
  // loading, otherwise the following slot of the held word. Presenting it at
  // the same edge that retires the current slot gives one move per cycle.
  assign pres_mv = (state == LOAD) ? slot_of(col_word, 0) : nxt_mv;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      col_ptr    <= '0;
      slot       <= '0;
      word_q     <= '0;
      col_rden   <= '0;
      move_out   <= '0;
      move_valid <= 1'b0;
      move_count <= '0;
      count_ovf  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      col_rden <= '0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            move_count <= '0;
            count_ovf  <= 1'b0;
            col_ptr    <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            state      <= WAITC;
          end
        end

        WAITC: begin
          if (col_done[col_ptr] && !col_empty[col_ptr]) begin
            col_rden <= ptr_onehot;
            state    <= POP;
          end
        end

        POP: state <= LOAD;

        LOAD: begin
          word_q     <= col_word;
          slot       <= '0;
          move_valid <= ~pres_mv[MOVW-1];
          if (!pres_mv[MOVW-1]) move_out <= pres_mv;
          state      <= EMIT;
        end

        EMIT: begin
          if (move_valid) begin
            // Hold move_out until accepted; only then retire the slot.
            if (move_ready) begin
              if (move_count == 8'hFF) count_ovf <= 1'b1;
              else                     move_count <= move_count + 8'd1;
              if (last_slot) begin
                move_valid <= 1'b0;
                col_rden   <= ptr_onehot;
                state      <= POP;
              end else begin
                slot       <= slot + 3'd1;
                move_valid <= ~pres_mv[MOVW-1];
                if (!pres_mv[MOVW-1]) move_out <= pres_mv;
              end
            end
          end else if (cur_end) begin
            // End marker: the rest of this word is discarded.
            if (last_col) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              col_ptr <= col_ptr + 3'd1;
              state   <= WAITC;
            end
          end else if (cur_inv) begin
            if (last_slot) begin
              col_rden <= ptr_onehot;
              state    <= POP;
            end else begin
              slot       <= slot + 3'd1;
              move_valid <= ~pres_mv[MOVW-1];
              if (!pres_mv[MOVW-1]) move_out <= pres_mv;
            end
          end else begin
            move_valid <= 1'b1;
            move_out   <= cur_mv;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_move_list_merger.sv
// tb/tb_move_list_merger.sv - scoreboard bench for move_list_merger
module tb_move_list_merger;

  localparam logic [18:0] ENDM   = 19'h40000;
  localparam logic [18:0] FILLER = 19'h40001;
  localparam logic [18:0] MV0    = 19'h00C1C;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    col_done;
  logic [7:0]    col_empty;
  logic [1215:0] col_data;
  logic [7:0]    col_rden;
  logic [18:0]   move_out;
  logic          move_valid;
  logic          move_ready;
  logic [7:0]    move_count;
  logic          count_ovf;
  logic          busy;
  logic          done;

  move_list_merger dut (
    .clk(clk), .reset(reset), .start(start), .col_done(col_done),
    .col_empty(col_empty), .col_data(col_data), .col_rden(col_rden),
    .move_out(move_out), .move_valid(move_valid), .move_ready(move_ready),
    .move_count(move_count), .count_ovf(count_ovf), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [151:0] fifo[8][$];
  logic [18:0]  exp_q[$];
  int           n_chk = 0;
  int           n_fail = 0;
  int           accepted, stall_left, release_step, first_valid, first_rden;
  int           rden_cnt[8];
  int           onehot_bad, waitc_bad;
  logic         chk_cnt = 1'b0;
  logic         prev_valid = 1'b0, prev_ready = 1'b0;
  logic [18:0]  prev_out = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe at the falling edge, model the FIFOs, pick move_ready,
  // and score any handshake that the next rising edge will complete.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if (col_rden[i]) begin
        rden_cnt[i]++;
        if (fifo[i].size() > 0) col_data[152*i +: 152] = fifo[i].pop_front();
      end
      col_empty[i] = (fifo[i].size() == 0);
    end
    if ($countones(col_rden) > 1) onehot_bad++;
    if (!col_done[2] && col_rden[7:2] != 6'd0) waitc_bad++;
    if (prev_valid && !prev_ready && !reset)
      chk("hold", {12'd0, move_valid, move_out}, {12'd0, 1'b1, prev_out});
    if (chk_cnt) begin
      chk("count", move_count, (accepted > 255) ? 255 : accepted);
      chk("ovf", count_ovf, accepted > 255);
    end
    if (move_valid && stall_left > 0) begin
      move_ready = 1'b0;
      stall_left--;
    end else begin
      move_ready = 1'b1;
    end
    if (move_valid && move_ready) begin
      accepted++;
      if (exp_q.size() == 0) chk("sb_extra_move", move_out, 32'hFFFFFFFF);
      else                   chk("move", move_out, exp_q.pop_front());
    end
    prev_valid = move_valid;
    prev_ready = move_ready;
    prev_out   = move_out;
  endtask

  task automatic load_column(input int col, input int n_real, input int fill_every,
                             input logic fixed_en);
    logic [18:0]  seq[$];
    logic [18:0]  m;
    logic [151:0] w;
    for (int k = 0; k < n_real; k++) begin
      if (fill_every > 0 && k % fill_every == 0) seq.push_back(FILLER);
      m = fixed_en ? MV0 : {1'b0, 18'($urandom)};
      seq.push_back(m);
      exp_q.push_back(m);
    end
    seq.push_back(ENDM);
    while (seq.size() % 8 != 0) seq.push_back(FILLER);
    for (int b = 0; b < seq.size(); b += 8) begin
      w = '0;
      for (int s = 0; s < 8; s++) w[151-19*s -: 19] = seq[b+s];
      fifo[col].push_back(w);
    end
    col_empty[col] = 1'b0;
  endtask

  task automatic run_pass();
    int n;
    accepted = 0; onehot_bad = 0; waitc_bad = 0;
    first_valid = -1; first_rden = -1;
    for (int i = 0; i < 8; i++) rden_cnt[i] = 0;
    chk_cnt = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    chk("busy_after_start", busy, 1);
    chk("done_after_start", done, 0);
    while (done !== 1'b1 && n < 4000) begin
      if (first_valid < 0 && move_valid) first_valid = n;
      if (first_rden < 0 && col_rden != 8'd0) first_rden = n;
      if (release_step > 0 && n == release_step) begin
        chk("stall_no_rden2", rden_cnt[2], 0);
        col_done = 8'hFF;
      end
      step();
      n++;
    end
    chk("pass_timeout", done, 1);
    chk("busy_at_done", busy, 0);
    chk("sb_left", exp_q.size(), 0);
    chk("onehot", onehot_bad, 0);
    chk_cnt = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; move_ready = 1'b1;
    col_done = 8'hFF; col_empty = 8'hFF; col_data = '0;
    stall_left = 0; release_step = 0; accepted = 0;
    step(); step();
    chk("rst_rden", col_rden, 0);
    chk("rst_out", move_out, 0);
    chk("rst_valid", move_valid, 0);
    chk("rst_count", move_count, 0);
    chk("rst_ovf", count_ovf, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    step();

    // One move per column, minimum latency
    for (int c = 0; c < 8; c++) load_column(c, 1, 0, 1'b1);
    run_pass();
    chk("single_count", move_count, 8);
    chk("single_lat_rden", first_rden, 2);
    chk("single_lat_valid", first_valid, 4);
    for (int c = 0; c < 8; c++) chk($sformatf("single_rden%0d", c), rden_cnt[c], 1);
    step();

    // Backpressure on the first move
    for (int c = 0; c < 8; c++) load_column(c, 1, 0, 1'b1);
    stall_left = 5;
    run_pass();
    chk("bp_count", move_count, 8);
    chk("bp_stall_used", stall_left, 0);

    // Multi-word column 3 with fillers elsewhere
    for (int c = 0; c < 8; c++) load_column(c, (c == 3) ? 16 : 2, (c == 3) ? 0 : 2, 1'b0);
    run_pass();
    chk("multi_rden3", rden_cnt[3], 3);
    chk("multi_count", move_count, 30);

    // Column 2 not done: stall in WAITC, then release
    for (int c = 0; c < 8; c++) load_column(c, 2, 2, 1'b0);
    col_done = 8'hFB;
    release_step = 40;
    run_pass();
    release_step = 0;
    chk("wait_no_early_rden", waitc_bad, 0);
    chk("wait_count", move_count, 16);

    // Saturation: 260 moves through column 0
    for (int c = 0; c < 8; c++) load_column(c, (c == 0) ? 260 : 0, 0, 1'b0);
    run_pass();
    chk("sat_count", move_count, 255);
    chk("sat_ovf", count_ovf, 1);
    chk("sat_emitted", accepted, 260);

    // Start from DONE clears the count and overflow flag
    for (int c = 0; c < 8; c++) load_column(c, 1, 0, 1'b0);
    run_pass();
    chk("clear_count", move_count, 8);
    chk("clear_ovf", count_ovf, 0);

    // Reset while a move is held under backpressure
    for (int c = 0; c < 8; c++) load_column(c, 3, 0, 1'b0);
    stall_left = 1000;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 50 && !move_valid; k++) step();
    chk("midrst_valid_before", move_valid, 1);
    reset = 1'b1;
    step();
    chk("midrst_rden", col_rden, 0);
    chk("midrst_out", move_out, 0);
    chk("midrst_valid", move_valid, 0);
    chk("midrst_count", move_count, 0);
    chk("midrst_ovf", count_ovf, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    reset = 1'b0;
    stall_left = 0;
    for (int c = 0; c < 8; c++) begin
      fifo[c].delete();
      col_empty[c] = 1'b1;
    end
    exp_q.delete();
    step();
    for (int c = 0; c < 8; c++) load_column(c, 2, 3, 1'b0);
    run_pass();
    chk("after_rst_count", move_count, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
